// File: rtl/alu_writeback_pkg.sv
// Shared widths, register-file geometry and ALU opcode encodings for the writeback stage.
package alu_writeback_pkg;

    localparam int WB_WIDTH          = 32;
    localparam int WB_NUM_REGS       = 16;
    localparam int WB_REG_ADDR_BITS  = $clog2(WB_NUM_REGS);
    localparam int ALU_WB_FIFO_DEPTH = 2;
    localparam int OPCODE_W          = 5;

    typedef logic [WB_REG_ADDR_BITS-1:0] reg_addr_t;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_CMP  = 5'd5,
        OP_MOVH = 5'd6,
        OP_MOV  = 5'd7
    } alu_op_e;

endpackage

// File: rtl/alu_writeback_wb_fifo.sv
// Synchronous FIFO holding packed {opcode, rd, data} ALU results ahead of writeback.
module alu_writeback_wb_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: result FIFO, load-priority write arbitration, MOVH/CMP shaping, register file.
// Optional same-cycle write-to-read forwarding is enabled by defining ALU_WB_BYPASS_EN.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH    = ALU_WB_FIFO_DEPTH,
    parameter int NUM_REGS = WB_NUM_REGS,
    parameter int DATA_W   = WB_WIDTH,
    localparam int RAW     = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [OPCODE_W-1:0] alu_opcode,
    input  logic [RAW-1:0]      alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    input  logic [RAW-1:0]      ld_rd,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic [RAW-1:0]      rd_addr_a,
    input  logic [RAW-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                wb_valid,
    output logic [RAW-1:0]      wb_rd,
    output logic [DATA_W-1:0]   wb_data
);

    localparam int ENTRY_W = OPCODE_W + RAW + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [OPCODE_W-1:0] head_op;
    logic [RAW-1:0]      head_rd;
    logic [DATA_W-1:0]   head_data;
    logic [DATA_W-1:0]   rf [NUM_REGS];

    // MOVH keeps the low half already in the destination; CMP reduces to its flag bit.
    function automatic logic [DATA_W-1:0] wb_merge(
        input logic [OPCODE_W-1:0] op,
        input logic [DATA_W-1:0]   head,
        input logic [DATA_W-1:0]   cur
    );
        case (op)
            OP_MOVH: wb_merge = {head[DATA_W-1:16], cur[15:0]};
            OP_CMP:  wb_merge = {{(DATA_W-1){1'b0}}, head[0]};
            default: wb_merge = head;
        endcase
    endfunction

    // Ready comes from the registered occupancy only, never from a same-cycle pop.
    assign alu_ready = (fifo_count != CNT_W'(DEPTH));
    assign fifo_push = alu_valid && !fifo_full;

    alu_writeback_wb_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({alu_opcode, alu_rd, alu_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_op   = fifo_head[ENTRY_W-1 -: OPCODE_W];
    assign head_rd   = fifo_head[DATA_W +: RAW];
    assign head_data = fifo_head[DATA_W-1:0];

    // Loads own the write port whenever present; the FIFO simply waits.
    always_comb begin
        fifo_pop = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = head_rd;
        wb_data  = wb_merge(head_op, head_data, rf[head_rd]);
        if (ld_valid) begin
            wb_valid = 1'b1;
            wb_rd    = ld_rd;
            wb_data  = ld_data;
        end else if (!fifo_empty) begin
            wb_valid = 1'b1;
            fifo_pop = 1'b1;
        end
    end

    // r0 is never written, so it holds its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_valid && (wb_rd != '0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : rf[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : rf[rd_addr_b];
`ifdef ALU_WB_BYPASS_EN
        if (wb_valid && (wb_rd == rd_addr_a) && (rd_addr_a != '0)) begin
            rd_data_a = wb_data;
        end
        if (wb_valid && (wb_rd == rd_addr_b) && (rd_addr_b != '0)) begin
            rd_data_b = wb_data;
        end
`else
        // Without forwarding the issue logic stalls a cycle on a read of the register being written.
`endif
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed vector bench for alu_writeback: table of per-cycle inputs/expectations plus hand-written corner sequences.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_opcode;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [31:0] ld_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_opcode (alu_opcode),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    typedef struct {
        logic        av;
        logic [4:0]  op;
        logic [3:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ldat;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        e_rdy;
        logic        e_wbv;
        logic [3:0]  e_wrd;
        logic [31:0] e_wdat;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic av, input logic [4:0] op, input logic [3:0] ard, input logic [31:0] adat,
        input logic lv, input logic [3:0] lrd, input logic [31:0] ldat,
        input logic [3:0] ra, input logic [3:0] rb,
        input logic e_rdy, input logic e_wbv, input logic [3:0] e_wrd, input logic [31:0] e_wdat,
        input logic [31:0] e_a, input logic [31:0] e_b
    );
        vec_t v;
        v.av = av; v.op = op; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.ra = ra; v.rb = rb;
        v.e_rdy = e_rdy; v.e_wbv = e_wbv; v.e_wrd = e_wrd; v.e_wdat = e_wdat;
        v.e_a = e_a; v.e_b = e_b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] op, input logic [3:0] ard, input logic [31:0] adat,
                         input logic lv, input logic [3:0] lrd, input logic [31:0] ldat,
                         input logic [3:0] ra, input logic [3:0] rb);
        alu_valid = av; alu_opcode = op; alu_rd = ard; alu_data = adat;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    initial begin
        logic [31:0] exp_byp;

        //             av op       ard   adat           lv lrd   ldat           ra    rb     rdy wbv wrd   wdat           a              b
        vecs[0]  = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd3, 4'd5,  1, 0, 4'd0, 32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1, OP_ADD,  4'd3, 32'h12345678, 0, 4'd0, 32'h0,        4'd3, 4'd5,  1, 0, 4'd0, 32'h0,        32'h0,        32'h0);
        vecs[2]  = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd0, 4'd0,  1, 1, 4'd3, 32'h12345678, 32'h0,        32'h0);
        vecs[3]  = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd3, 4'd0,  1, 0, 4'd0, 32'h0,        32'h12345678, 32'h0);
        vecs[4]  = mk(0, OP_ADD,  4'd0, 32'h0,        1, 4'd5, 32'h0000BEEF, 4'd3, 4'd0,  1, 1, 4'd5, 32'h0000BEEF, 32'h12345678, 32'h0);
        vecs[5]  = mk(1, OP_MOVH, 4'd5, 32'hCAFE0000, 0, 4'd0, 32'h0,        4'd5, 4'd3,  1, 0, 4'd0, 32'h0,        32'h0000BEEF, 32'h12345678);
        vecs[6]  = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd3, 4'd0,  1, 1, 4'd5, 32'hCAFEBEEF, 32'h12345678, 32'h0);
        vecs[7]  = mk(1, OP_CMP,  4'd2, 32'hFFFFFFFF, 0, 4'd0, 32'h0,        4'd5, 4'd0,  1, 0, 4'd0, 32'h0,        32'hCAFEBEEF, 32'h0);
        vecs[8]  = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd3, 4'd0,  1, 1, 4'd2, 32'h00000001, 32'h12345678, 32'h0);
        vecs[9]  = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd2, 4'd5,  1, 0, 4'd0, 32'h0,        32'h00000001, 32'hCAFEBEEF);
        vecs[10] = mk(1, OP_ADD,  4'd9, 32'h99999999, 1, 4'd8, 32'h11111111, 4'd3, 4'd0,  1, 1, 4'd8, 32'h11111111, 32'h12345678, 32'h0);
        vecs[11] = mk(1, OP_ADD, 4'd11, 32'hBBBBBBBB, 1, 4'd10,32'h22222222, 4'd8, 4'd0,  1, 1, 4'd10,32'h22222222, 32'h11111111, 32'h0);
        vecs[12] = mk(1, OP_ADD, 4'd13, 32'hDDDDDDDD, 1, 4'd12,32'h33333333, 4'd10,4'd0,  0, 1, 4'd12,32'h33333333, 32'h22222222, 32'h0);
        vecs[13] = mk(1, OP_ADD, 4'd13, 32'hDDDDDDDD, 0, 4'd0, 32'h0,        4'd12,4'd0,  0, 1, 4'd9, 32'h99999999, 32'h33333333, 32'h0);
        vecs[14] = mk(1, OP_ADD, 4'd13, 32'hDDDDDDDD, 0, 4'd0, 32'h0,        4'd9, 4'd0,  1, 1, 4'd11,32'hBBBBBBBB, 32'h99999999, 32'h0);
        vecs[15] = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd8, 4'd11, 1, 1, 4'd13,32'hDDDDDDDD, 32'h11111111, 32'hBBBBBBBB);
        vecs[16] = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd12,4'd13, 1, 0, 4'd0, 32'h0,        32'h33333333, 32'hDDDDDDDD);
        vecs[17] = mk(1, OP_ADD,  4'd0, 32'hFFFFFFFF, 0, 4'd0, 32'h0,        4'd10,4'd11, 1, 0, 4'd0, 32'h0,        32'h22222222, 32'hBBBBBBBB);
        vecs[18] = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd0, 4'd0,  1, 1, 4'd0, 32'hFFFFFFFF, 32'h0,        32'h0);
        vecs[19] = mk(0, OP_ADD,  4'd0, 32'h0,        1, 4'd0, 32'h00000005, 4'd0, 4'd0,  1, 1, 4'd0, 32'h00000005, 32'h0,        32'h0);
        vecs[20] = mk(0, OP_ADD,  4'd0, 32'h0,        0, 4'd0, 32'h0,        4'd0, 4'd3,  1, 0, 4'd0, 32'h0,        32'h0,        32'h12345678);
        vecs[21] = mk(0, OP_ADD,  4'd0, 32'h0,        1, 4'd7, 32'h0BADF00D, 4'd3, 4'd0,  1, 1, 4'd7, 32'h0BADF00D, 32'h12345678, 32'h0);
        vecs[22] = mk(1, OP_ADD,  4'd7, 32'hA5A5A5A5, 0, 4'd0, 32'h0,        4'd0, 4'd7,  1, 0, 4'd0, 32'h0,        32'h0,        32'h0BADF00D);

        rst_n = 1'b0;
        drive(0, OP_ADD, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset alu_ready", 32'(alu_ready), 32'd1);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].op, vecs[i].ard, vecs[i].adat,
                  vecs[i].lv, vecs[i].lrd, vecs[i].ldat, vecs[i].ra, vecs[i].rb);
            #1;
            chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
            if (vecs[i].e_wbv) begin
                chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_wrd));
                chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_wdat);
            end
            chk($sformatf("v%0d rd_data_a", i), rd_data_a, vecs[i].e_a);
            chk($sformatf("v%0d rd_data_b", i), rd_data_b, vecs[i].e_b);
        end

        // Same-cycle read of r7 while the buffered A5A5A5A5 is committed over 0BADF00D.
`ifdef ALU_WB_BYPASS_EN
        exp_byp = 32'hA5A5A5A5;
`else
        exp_byp = 32'h0BADF00D;
`endif
        @(negedge clk);
        drive(0, OP_ADD, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd5, 4'd7);
        #1;
        chk("bypass wb_valid", 32'(wb_valid), 32'd1);
        chk("bypass wb_rd", 32'(wb_rd), 32'd7);
        chk("bypass wb_data", wb_data, 32'hA5A5A5A5);
        chk("bypass rd_data_b", rd_data_b, exp_byp);
        chk("bypass rd_data_a", rd_data_a, 32'hCAFEBEEF);
        @(negedge clk);
        #1;
        chk("after bypass wb_valid", 32'(wb_valid), 32'd0);
        chk("after bypass rd_data_b", rd_data_b, 32'hA5A5A5A5);

        // Fill the FIFO behind a stream of loads, then reset asynchronously mid-cycle.
        @(negedge clk);
        drive(1, OP_ADD, 4'd14, 32'h14141414, 1, 4'd1, 32'h01010101, 4'd1, 4'd0);
        #1;
        chk("fill0 alu_ready", 32'(alu_ready), 32'd1);
        @(negedge clk);
        drive(1, OP_ADD, 4'd15, 32'h15151515, 1, 4'd1, 32'h01010101, 4'd1, 4'd0);
        #1;
        chk("fill1 alu_ready", 32'(alu_ready), 32'd1);
        chk("fill1 wb_rd", 32'(wb_rd), 32'd1);
        @(negedge clk);
        drive(0, OP_ADD, 4'd0, 32'h0, 1, 4'd1, 32'h01010101, 4'd1, 4'd0);
        #1;
        chk("full alu_ready", 32'(alu_ready), 32'd0);
        chk("full rd_data_a r1", rd_data_a, 32'h01010101);
        drive(0, OP_ADD, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("async reset alu_ready", 32'(alu_ready), 32'd1);
        chk("async reset wb_valid", 32'(wb_valid), 32'd0);
        for (int r = 1; r < 16; r++) begin
            rd_addr_a = 4'(r);
            #1;
            chk($sformatf("async reset r%0d", r), rd_data_a, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr_a = 4'd14;
        rd_addr_b = 4'd15;
        #1;
        chk("post reset wb_valid", 32'(wb_valid), 32'd0);
        chk("post reset alu_ready", 32'(alu_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("flushed wb_valid", 32'(wb_valid), 32'd0);
        chk("flushed r14", rd_data_a, 32'h0);
        chk("flushed r15", rd_data_b, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Writeback stage directly downstream of the ALU. Accepts ALU results through a valid/ready handshake and buffers them in a small FIFO. Arbitrates them against load-return writes and commits one write per cycle into the architectural register file. Also owns the two combinational register read ports that supply the ALU's A and B operands.

Parameters:
DEPTH, 2, ALU result FIFO entries (power of two, >=2)
NUM_REGS, 16, architectural registers; r0 reads zero, writes to r0 discarded
WIDTH, `WIDTH (32), data width from defines.vh

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result present
alu_ready  out  1  stage can accept ALU result (FIFO not full)
alu_opcode  in  5  opcode of the result (`MOVH, `CMP, others)
alu_rd  in  log2(NUM_REGS)  destination register
alu_data  in  WIDTH  ALU z_data
ld_valid  in  1  load return write; no backpressure, always wins the port
ld_rd  in  log2(NUM_REGS)  load destination
ld_data  in  WIDTH  load data
rd_addr_a / rd_addr_b  in  log2(NUM_REGS)  operand read addresses
rd_data_a / rd_data_b  out  WIDTH  operand read data, combinational
wb_valid  out  1  a register write commits at the next rising edge
wb_rd  out  log2(NUM_REGS)  register being written
wb_data  out  WIDTH  final value being written, after merge/mask

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, count 0, all registers 0. After reset: alu_ready=1, wb_valid=0.
- Reset mid-operation flushes all FIFO contents; buffered results are lost.
- Accept: push on the rising edge where alu_valid && alu_ready. alu_ready = (count != DEPTH), derived from registered count only; it does not depend on a same-cycle pop.
- Pop/write select, one write per cycle, fixed priority:
  - ld_valid=1: write ld_data to ld_rd; the FIFO holds.
  - else, FIFO non-empty: pop the head and write it.
  - else: wb_valid=0.
- Minimum ALU latency: a result accepted at edge N is written to the register file no earlier than edge N+1.
- Loads may starve the FIFO indefinitely; this is permitted.
- Head value formation at write time:
  - `MOVH: wb_data = {head_data[31:16], rf[head_rd][15:0]}, using current register contents.
  - `CMP: wb_data = {31'b0, head_data[0]}.
  - All other opcodes: wb_data = head_data unmodified.
- Register write: rf[wb_rd] <= wb_data when wb_valid and wb_rd != 0. wb_valid still asserts for rd=0, but no state changes.
- Read ports: rd_data_x = 0 when rd_addr_x == 0; otherwise rf[rd_addr_x], subject to the optional bypass.
- Count update: push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.

Optional Feature:
ALU_WB_BYPASS_EN
- Defined: when wb_valid && wb_rd == rd_addr_x && rd_addr_x != 0, rd_data_x = wb_data in the same cycle (write-before-read).
- Undefined: read ports return pre-write register contents; the issue logic must stall one cycle on that hazard.

Decomposition:
- defines.vh gains NUM_REGS, REG_ADDR_BITS and ALU_WB_FIFO_DEPTH, next to the existing opcode and `WIDTH defines.
- Sub-module wb_fifo: synchronous FIFO parameterised on width and depth, with push, pop, full, empty and count outputs. It stores {opcode, rd, data}.
- alu_writeback contains the arbitration, merge/mask logic and the register array.

Test Plan:
- Reset, then alu_valid with `ADD, rd=3, data=0x12345678 and no load -> wb_valid, wb_rd=3, wb_data=0x12345678 on the following cycle; rd_addr_a=3 then reads 0x12345678.
- r5=0x0000BEEF, then `MOVH rd=5 with data=0xCAFE0000 -> r5=0xCAFEBEEF.
- `CMP rd=2 with data=0xFFFFFFFF -> r2=0x00000001.
- ld_valid held 3 cycles while 3 ALU results arrive -> loads written first; alu_ready=0 after 2 accepts (DEPTH=2); ALU results then drain in order.
- Write rd=0 with 0xFFFFFFFF -> wb_valid=1, rd_data_a for address 0 stays 0.
- With ALU_WB_BYPASS_EN, a write to r7=0xA5A5A5A5 with rd_addr_b=7 in the same cycle -> rd_data_b=0xA5A5A5A5. Without the macro -> old r7 value. Then assert rst_n=0 with a full FIFO -> alu_ready=1, wb_valid=0, all registers 0.
